// File: rtl/snake_pkg.sv
// snake_pkg: direction/state types and the opposite-direction helper shared by the snake controller
package snake_pkg;

    typedef enum logic [1:0] {
        DIR_YPOS = 2'd0,
        DIR_YNEG = 2'd1,
        DIR_XNEG = 2'd2,
        DIR_XPOS = 2'd3
    } dir_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        INIT  = 3'd1,
        RUN   = 3'd2,
        PAUSE = 3'd3,
        OVER  = 3'd4
    } state_t;

    // Two directions are opposite when they share an axis but differ in sign
    function automatic logic opposite(dir_t a, dir_t b);
        return (a[1] == b[1]) && (a[0] != b[0]);
    endfunction

endpackage

// File: rtl/snake_game_ctrl_if.sv
// snake_game_ctrl_if: button/engine signals between the game controller and its surroundings
interface snake_game_ctrl_if;
    import snake_pkg::*;

    logic       dir_req_valid;
    dir_t       dir_req;
    logic       start;
    logic       pause;
    logic       collision;
    logic       food_eaten;
    logic       step;
    dir_t       direction;
    logic       engine_reset_n;
    state_t     game_state;
    logic [7:0] score;
    logic [2:0] level;

    modport master (
        input  dir_req_valid, dir_req, start, pause, collision, food_eaten,
        output step, direction, engine_reset_n, game_state, score, level
    );

    modport slave (
        output dir_req_valid, dir_req, start, pause, collision, food_eaten,
        input  step, direction, engine_reset_n, game_state, score, level
    );

endinterface

// File: rtl/snake_tick_gen.sv
// snake_tick_gen: move-rate counter that wraps at period-1 and flags the wrap for one cycle
module snake_tick_gen #(
    parameter int unsigned W = 24
) (
    input  logic         game_clk,
    input  logic         reset_n,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] period,
    output logic         wrap
);
    logic [W-1:0] cnt_q, cnt_d;

    // A shrinking period can leave the count past the new end, so wrap on >= rather than ==
    assign wrap = en && (cnt_q >= period - W'(1));

    // Next count: cleared on init or wrap, advanced when enabled, otherwise held
    always_comb cnt_d = (clr || wrap) ? '0 : en ? cnt_q + W'(1) : cnt_q;

    // Counter register
    always_ff @(posedge game_clk) cnt_q <= !reset_n ? '0 : cnt_d;

endmodule

// File: rtl/snake_game_ctrl.sv
// snake_game_ctrl: game FSM, move strobe timing, direction latch and score/level keeping
module snake_game_ctrl
    import snake_pkg::*;
#(
    parameter int unsigned TICK_BASE      = 12_500_000,
    parameter int unsigned TICK_DEC       = 1_000_000,
    parameter int unsigned MAX_LEVEL      = 7,
    parameter int unsigned FOOD_PER_LEVEL = 4
) (
    input  logic              game_clk,
    input  logic              reset_n,
    snake_game_ctrl_if.master bus
);
    localparam int unsigned CW = $clog2(TICK_BASE + 1);
    localparam int unsigned FW = $clog2(FOOD_PER_LEVEL + 1);

    state_t        state_q, state_d;
    dir_t          dir_q, dir_d, pend_q, pend_d;
    logic          step_q, step_d, ern_q, ern_d;
    logic [7:0]    score_q, score_d;
    logic [2:0]    level_q, level_d;
    logic [FW-1:0] food_q, food_d;
    logic [CW-1:0] period;
    logic          run, tick_en, move;

    assign run     = state_q == RUN;
    assign period  = CW'(TICK_BASE) - CW'(level_q) * CW'(TICK_DEC);
    // Counter freezes on the cycle that leaves RUN so a pause holds the current count
    assign tick_en = run && !bus.collision && !bus.pause;

    snake_tick_gen #(.W(CW)) u_tick (
        .game_clk (game_clk),
        .reset_n  (reset_n),
        .en       (tick_en),
        .clr      (state_q == INIT),
        .period   (period),
        .wrap     (move)
    );

    // Next-state, direction latch and score/level update
    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        pend_d  = pend_q;
        score_d = score_q;
        level_d = level_q;
        food_d  = food_q;
        step_d  = move;
        if ((run || state_q == PAUSE) && bus.dir_req_valid && !opposite(bus.dir_req, dir_q))
            pend_d = bus.dir_req;
        if (move)
            dir_d = pend_q;
        if (run && bus.food_eaten && !bus.collision) begin
            score_d = (score_q == 8'hff) ? score_q : score_q + 8'd1;
            if (food_q == FW'(FOOD_PER_LEVEL - 1)) begin
                food_d  = '0;
                level_d = (level_q == 3'(MAX_LEVEL)) ? level_q : level_q + 3'd1;
            end else begin
                food_d = food_q + FW'(1);
            end
        end
        case (state_q)
            IDLE:    state_d = bus.start ? INIT : IDLE;
            INIT: begin
                state_d = RUN;
                dir_d   = DIR_XPOS;
                pend_d  = DIR_XPOS;
                score_d = '0;
                level_d = '0;
                food_d  = '0;
            end
            RUN:     state_d = bus.collision ? OVER : bus.pause ? PAUSE : RUN;
            PAUSE:   state_d = bus.pause ? RUN : PAUSE;
            OVER:    state_d = bus.start ? INIT : OVER;
            default: state_d = IDLE;
        endcase
        ern_d = state_d inside {RUN, PAUSE, OVER};
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge game_clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            dir_q   <= DIR_XPOS;
            pend_q  <= DIR_XPOS;
            step_q  <= 1'b0;
            ern_q   <= 1'b0;
            score_q <= '0;
            level_q <= '0;
            food_q  <= '0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            pend_q  <= pend_d;
            step_q  <= step_d;
            ern_q   <= ern_d;
            score_q <= score_d;
            level_q <= level_d;
            food_q  <= food_d;
        end
    end

    assign bus.step           = step_q;
    assign bus.direction      = dir_q;
    assign bus.engine_reset_n = ern_q;
    assign bus.game_state     = state_q;
    assign bus.score          = score_q;
    assign bus.level          = level_q;

endmodule

// File: tb/tb_snake_game_ctrl.sv
// tb_snake_game_ctrl: directed and random stimulus checked against a behavioural game model
module tb_snake_game_ctrl;
    import snake_pkg::*;

    localparam int TB = 10, TD = 2, ML = 3, FPL = 2;

    logic game_clk = 1'b0;
    logic reset_n;
    int   n_chk = 0, n_fail = 0;
    int   m_state, m_cnt, m_dir, m_pend, m_score, m_level, m_food, m_step;
    bit   i_rst, i_st, i_pa, i_co, i_fe, i_dv;
    int   i_dr;
    int   n;

    snake_game_ctrl_if bus();

    snake_game_ctrl #(
        .TICK_BASE(TB), .TICK_DEC(TD), .MAX_LEVEL(ML), .FOOD_PER_LEVEL(FPL)
    ) dut (
        .game_clk (game_clk),
        .reset_n  (reset_n),
        .bus      (bus)
    );

    always #5 game_clk = ~game_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Game rules applied once per clock edge; states numbered IDLE=0 INIT=1 RUN=2 PAUSE=3 OVER=4
    task automatic model();
        int p, np;
        if (!i_rst) begin
            m_state = 0; m_step = 0; m_dir = 3; m_pend = 3;
            m_score = 0; m_level = 0; m_food = 0; m_cnt = 0;
            return;
        end
        p = TB - TD * m_level;
        np = m_pend;
        m_step = 0;
        if ((m_state == 2 || m_state == 3) && i_dv && (i_dr ^ m_dir) != 1) np = i_dr;
        case (m_state)
            0: if (i_st) m_state = 1;
            1: begin
                m_state = 2; m_cnt = 0; m_score = 0; m_level = 0; m_food = 0;
                m_dir = 3; np = 3;
            end
            2: if (i_co) m_state = 4;
               else begin
                   if (i_fe) begin
                       m_score = (m_score < 255) ? m_score + 1 : 255;
                       m_food++;
                       if (m_food == FPL) begin
                           m_food = 0;
                           if (m_level < ML) m_level++;
                       end
                   end
                   if (i_pa) m_state = 3;
                   else if (m_cnt >= p - 1) begin
                       m_cnt = 0; m_step = 1; m_dir = m_pend;
                   end else m_cnt++;
               end
            3: if (i_pa) m_state = 2;
            4: if (i_st) m_state = 1;
            default: ;
        endcase
        m_pend = np;
    endtask

    task automatic tick();
        reset_n           = i_rst;
        bus.start         = i_st;
        bus.pause         = i_pa;
        bus.collision     = i_co;
        bus.food_eaten    = i_fe;
        bus.dir_req_valid = i_dv;
        bus.dir_req       = dir_t'(2'(i_dr));
        @(posedge game_clk);
        model();
        #1;
        check("state", bus.game_state, m_state);
        check("step", bus.step, m_step);
        check("direction", bus.direction, m_dir);
        check("engine_reset_n", bus.engine_reset_n, m_state >= 2);
        check("score", bus.score, m_score);
        check("level", bus.level, m_level);
        i_st = 0; i_pa = 0; i_co = 0; i_fe = 0; i_dv = 0;
    endtask

    task automatic run_to_step(output int cyc);
        cyc = 0;
        for (int k = 1; k <= 40 && cyc == 0; k++) begin
            tick();
            if (bus.step) cyc = k;
        end
        if (cyc == 0) check("step_timeout", bus.step, 1);
    endtask

    task automatic wait_cnt(input int target);
        for (int k = 0; k < 40 && !(m_state == 2 && m_cnt == target); k++) tick();
        check("cnt_reach", m_cnt, target);
    endtask

    initial begin
        i_rst = 0; i_st = 0; i_pa = 0; i_co = 0; i_fe = 0; i_dv = 0; i_dr = 0;
        repeat (3) tick();
        i_rst = 1;
        i_st = 1;
        tick();
        check("init_engine_reset", bus.engine_reset_n, 0);
        tick();
        run_to_step(n);
        check("first_step_latency", n, 10);
        i_dv = 1; i_dr = 2; tick();
        i_dv = 1; i_dr = 0; tick();
        i_dv = 1; i_dr = 2; tick();
        run_to_step(n);
        check("dir_after_step", bus.direction, 0);
        wait_cnt(5);
        i_pa = 1; tick();
        repeat (20) tick();
        i_pa = 1; tick();
        run_to_step(n);
        check("resume_step_latency", n, 5);
        i_fe = 1; tick();
        i_fe = 1; tick();
        check("level_after_2_food", bus.level, 1);
        run_to_step(n);
        run_to_step(n);
        check("period_level1", n, 8);
        repeat (6) begin i_fe = 1; tick(); end
        check("level_saturated", bus.level, 3);
        run_to_step(n);
        run_to_step(n);
        check("period_level3", n, 4);
        repeat (260) begin i_fe = 1; tick(); end
        check("score_saturated", bus.score, 255);
        i_co = 1; i_fe = 1; tick();
        check("over_on_collision", bus.game_state, OVER);
        check("score_held_on_collision", bus.score, 255);
        repeat (12) tick();
        i_st = 1; tick();
        tick();
        check("restart_score", bus.score, 0);
        check("restart_level", bus.level, 0);
        i_fe = 1; tick();
        wait_cnt(TB - 1);
        i_rst = 0; tick();
        check("reset_step", bus.step, 0);
        check("reset_state", bus.game_state, IDLE);
        i_rst = 1;
        repeat (3000) begin
            i_rst = $urandom_range(0, 299) != 0;
            i_st  = $urandom_range(0, 19) == 0;
            i_pa  = $urandom_range(0, 24) == 0;
            i_co  = $urandom_range(0, 49) == 0;
            i_fe  = $urandom_range(0, 4) == 0;
            i_dv  = $urandom_range(0, 2) == 0;
            i_dr  = int'($urandom_range(0, 3));
            tick();
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
